// File: rtl/priority_dispatch_if.sv
// priority_dispatch_if: upstream beat, per-output streams and status.
// slave = dispatcher view, master = driver/consumer view.
interface priority_dispatch_if #(
  parameter int OutputWidth = 4,
  parameter int DataWidth   = 8
);
  localparam int IdxW =
    (OutputWidth > 1) ? $clog2(OutputWidth) : 1;

  logic                                  in_vld_i;
  logic                                  in_rdy_o;
  logic [DataWidth-1:0]                  in_data_i;
  logic                                  in_last_i;
  logic [OutputWidth-1:0]                en_mask_i;
  logic [OutputWidth-1:0]                out_vld_o;
  logic [OutputWidth-1:0]                out_rdy_i;
  logic [OutputWidth-1:0][DataWidth-1:0] out_data_o;
  logic [OutputWidth-1:0]                out_last_o;
  logic                                  busy_o;
  logic [IdxW-1:0]                       lock_idx_o;
  logic [OutputWidth-1:0][15:0]          beat_cnt_o;

  modport slave (
    input  in_vld_i, in_data_i, in_last_i,
    input  en_mask_i, out_rdy_i,
    output in_rdy_o, out_vld_o, out_data_o,
    output out_last_o, busy_o, lock_idx_o,
    output beat_cnt_o
  );

  modport master (
    output in_vld_i, in_data_i, in_last_i,
    output en_mask_i, out_rdy_i,
    input  in_rdy_o, out_vld_o, out_data_o,
    input  out_last_o, busy_o, lock_idx_o,
    input  beat_cnt_o
  );
endinterface

// File: rtl/priority_dispatch.sv
// priority_dispatch: routes each upstream beat to the lowest free enabled
// output; packets stay locked to one output until last.
// Ports: clk, rst_n (async low), bus (priority_dispatch_if.slave).
// Optional PRIORITY_DISPATCH_CNT_EN: saturating per-output beat counters.
module priority_dispatch #(
  parameter int OutputWidth = 4,
  parameter int DataWidth   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  priority_dispatch_if.slave   bus
);
  localparam int IdxW =
    (OutputWidth > 1) ? $clog2(OutputWidth) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                                state_q, state_d;
  logic [IdxW-1:0]                       lock_q, lock_d;
  logic [IdxW-1:0]                       tgt_idx;
  logic [OutputWidth-1:0]                vld_q, last_q;
  logic [OutputWidth-1:0][DataWidth-1:0] data_q;
  logic [OutputWidth-1:0]                free, cand, target;
  logic                                  rdy, accept;

  // A slot can take a beat if empty or draining this cycle.
  assign free   = ~vld_q | bus.out_rdy_i;
  assign cand   = bus.en_mask_i & free;
  assign accept = bus.in_vld_i & rdy;

  always_comb begin
    target  = '0;
    rdy     = 1'b0;
    tgt_idx = '0;
    state_d = state_q;
    lock_d  = lock_q;
    unique case (state_q)
      IDLE: begin
        // Isolate lowest set bit of cand.
        target = cand & (~cand + OutputWidth'(1));
        rdy    = |cand;
      end
      LOCKED: begin
        target = OutputWidth'(1) << lock_q;
        rdy    = free[lock_q];
      end
      default: ;
    endcase
    for (int i = OutputWidth - 1; i >= 0; i--) begin
      if (target[i]) tgt_idx = IdxW'(i);
    end
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.in_last_i) begin
            state_d = LOCKED;
            lock_d  = tgt_idx;
          end
        end
        LOCKED: begin
          if (bus.in_last_i) begin
            state_d = IDLE;
            lock_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
      data_q <= '0;
    end else begin
      for (int i = 0; i < OutputWidth; i++) begin
        if (accept && target[i]) begin
          vld_q[i]  <= 1'b1;
          data_q[i] <= bus.in_data_i;
          last_q[i] <= bus.in_last_i;
        end else if (bus.out_rdy_i[i]) begin
          vld_q[i]  <= 1'b0;
        end
      end
    end
  end

  assign bus.in_rdy_o   = rdy;
  assign bus.out_vld_o  = vld_q;
  assign bus.out_data_o = data_q;
  assign bus.out_last_o = last_q;
  assign bus.busy_o     = (state_q == LOCKED);
  assign bus.lock_idx_o = lock_q;

`ifdef PRIORITY_DISPATCH_CNT_EN
  logic [OutputWidth-1:0][15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < OutputWidth; i++) begin
        if (vld_q[i] && bus.out_rdy_i[i] &&
            cnt_q[i] != 16'hFFFF) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign bus.beat_cnt_o = cnt_q;
`else
  assign bus.beat_cnt_o = '0;
`endif
endmodule

// File: tb/tb_priority_dispatch.sv
// tb_priority_dispatch: vector table, directed corner sequences and
// randomized traffic against a slot/lock reference model.
module tb_priority_dispatch;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  priority_dispatch_if #(.OutputWidth(N), .DataWidth(DW)) bus();

  priority_dispatch #(.OutputWidth(N), .DataWidth(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] en,
                       input logic [N-1:0] ordy,
                       input logic v,
                       input logic [DW-1:0] d,
                       input logic l);
    bus.en_mask_i = en;
    bus.out_rdy_i = ordy;
    bus.in_vld_i  = v;
    bus.in_data_i = d;
    bus.in_last_i = l;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0]  en;
    logic [N-1:0]  ordy;
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    logic          exp_rdy;
    logic [N-1:0]  exp_vld;
    int            idx;
    logic [DW-1:0] exp_data;
    logic          exp_busy;
  } vec_t;

  vec_t tbl[9];

  // Reference model state
  bit          mv[N];
  logic [7:0]  md[N];
  bit          ml[N];
  int          lk;
  int unsigned mc[N];

  initial begin
    tbl[0] = '{4'b1110, 4'b1111, 1'b1, 8'hA5, 1'b1,
               1'b1, 4'b0010, 1, 8'hA5, 1'b0};
    tbl[1] = '{4'b0000, 4'b1111, 1'b0, 8'h00, 1'b0,
               1'b0, 4'b0000, -1, 8'h00, 1'b0};
    tbl[2] = '{4'b1111, 4'b0000, 1'b1, 8'h01, 1'b1,
               1'b1, 4'b0001, 0, 8'h01, 1'b0};
    tbl[3] = '{4'b1111, 4'b0000, 1'b1, 8'h02, 1'b1,
               1'b1, 4'b0011, 1, 8'h02, 1'b0};
    tbl[4] = '{4'b1111, 4'b0000, 1'b1, 8'h03, 1'b1,
               1'b1, 4'b0111, 2, 8'h03, 1'b0};
    tbl[5] = '{4'b1111, 4'b0000, 1'b1, 8'h04, 1'b1,
               1'b1, 4'b1111, 3, 8'h04, 1'b0};
    tbl[6] = '{4'b1111, 4'b0000, 1'b1, 8'h05, 1'b1,
               1'b0, 4'b1111, 3, 8'h04, 1'b0};
    tbl[7] = '{4'b1111, 4'b0100, 1'b1, 8'h06, 1'b1,
               1'b1, 4'b1111, 2, 8'h06, 1'b0};
    tbl[8] = '{4'b1111, 4'b1111, 1'b0, 8'h00, 1'b0,
               1'b1, 4'b0000, -1, 8'h00, 1'b0};

    drive('0, '0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;

    chk("rst_vld", bus.out_vld_o, 0);
    chk("rst_data", bus.out_data_o, 0);
    chk("rst_last", bus.out_last_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_lock", bus.lock_idx_o, 0);
    chk("rst_cnt", bus.beat_cnt_o, 0);
    #1;
    chk("mask0_rdy", bus.in_rdy_o, 0);

    for (int k = 0; k < 9; k++) begin
      drive(tbl[k].en, tbl[k].ordy, tbl[k].v,
            tbl[k].d, tbl[k].l);
      #1;
      chk($sformatf("tbl%0d_rdy", k), bus.in_rdy_o,
          tbl[k].exp_rdy);
      tick;
      chk($sformatf("tbl%0d_vld", k), bus.out_vld_o,
          tbl[k].exp_vld);
      chk($sformatf("tbl%0d_busy", k), bus.busy_o,
          tbl[k].exp_busy);
      if (tbl[k].idx >= 0) begin
        chk($sformatf("tbl%0d_data", k),
            bus.out_data_o[tbl[k].idx], tbl[k].exp_data);
      end
      if (k == 0) chk("tbl0_last", bus.out_last_o[1], 1);
    end

    // Packet lock across a mask change
    drive(4'b0100, 4'b1111, 1'b1, 8'h10, 1'b0);
    #1 chk("lk_rdy0", bus.in_rdy_o, 1);
    tick;
    chk("lk_vld0", bus.out_vld_o, 4'b0100);
    chk("lk_dat0", bus.out_data_o[2], 8'h10);
    chk("lk_busy0", bus.busy_o, 1);
    chk("lk_idx0", bus.lock_idx_o, 2);
    drive(4'b0001, 4'b1111, 1'b1, 8'h11, 1'b0);
    #1 chk("lk_rdy1", bus.in_rdy_o, 1);
    tick;
    chk("lk_vld1", bus.out_vld_o, 4'b0100);
    chk("lk_dat1", bus.out_data_o[2], 8'h11);
    chk("lk_idx1", bus.lock_idx_o, 2);
    drive(4'b0001, 4'b1111, 1'b1, 8'h12, 1'b1);
    tick;
    chk("lk_vld2", bus.out_vld_o, 4'b0100);
    chk("lk_dat2", bus.out_data_o[2], 8'h12);
    chk("lk_last2", bus.out_last_o[2], 1);
    chk("lk_busy2", bus.busy_o, 0);
    chk("lk_idx2", bus.lock_idx_o, 0);
    drive(4'b0001, 4'b1111, 1'b0, 8'h00, 1'b0);
    tick;
    chk("lk_drain", bus.out_vld_o, 0);

    // Locked stall on output 1
    drive(4'b0010, 4'b1111, 1'b1, 8'h20, 1'b0);
    tick;
    chk("st_idx", bus.lock_idx_o, 1);
    drive(4'b0010, 4'b0000, 1'b1, 8'h21, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("st_rdy", bus.in_rdy_o, 0);
      tick;
      chk("st_vld", bus.out_vld_o, 4'b0010);
      chk("st_dat", bus.out_data_o[1], 8'h20);
      chk("st_busy", bus.busy_o, 1);
    end
    drive(4'b0010, 4'b0010, 1'b1, 8'h21, 1'b0);
    #1 chk("st_rdy_go", bus.in_rdy_o, 1);
    tick;
    chk("st_dat2", bus.out_data_o[1], 8'h21);
    chk("st_vld2", bus.out_vld_o, 4'b0010);
    drive(4'b0010, 4'b1111, 1'b1, 8'h22, 1'b1);
    tick;
    chk("st_dat3", bus.out_data_o[1], 8'h22);
    chk("st_busy3", bus.busy_o, 0);
    drive(4'b0000, 4'b1111, 1'b0, 8'h00, 1'b0);
    tick;
    chk("st_drain", bus.out_vld_o, 0);

    // Reset mid-packet
    drive(4'b0001, 4'b0000, 1'b1, 8'h30, 1'b0);
    tick;
    chk("rm_busy", bus.busy_o, 1);
    chk("rm_vld", bus.out_vld_o, 4'b0001);
    drive(4'b0001, 4'b0000, 1'b0, 8'h00, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("rm_vld_rst", bus.out_vld_o, 0);
    chk("rm_busy_rst", bus.busy_o, 0);
    chk("rm_idx_rst", bus.lock_idx_o, 0);
    tick;
    tick;
    rst_n = 1'b1;
    drive(4'b0001, 4'b1111, 1'b1, 8'h77, 1'b1);
    #1 chk("rm_rdy", bus.in_rdy_o, 1);
    tick;
    chk("rm_vld2", bus.out_vld_o, 4'b0001);
    chk("rm_dat2", bus.out_data_o[0], 8'h77);
    chk("rm_busy2", bus.busy_o, 0);
    drive(4'b0000, 4'b1111, 1'b0, 8'h00, 1'b0);
    tick;

`ifdef PRIORITY_DISPATCH_CNT_EN
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      drive(4'b1000, 4'b1111, 1'b1, 8'(k), 1'b1);
      tick;
    end
    drive(4'b1000, 4'b1111, 1'b0, 8'h00, 1'b0);
    tick;
    chk("cnt300", bus.beat_cnt_o, {16'd300, 48'h0});
    drive(4'b1000, 4'b1111, 1'b1, 8'h55, 1'b1);
    for (int k = 0; k < 70000; k++) tick;
    drive(4'b1000, 4'b1111, 1'b0, 8'h00, 1'b0);
    tick;
    chk("cnt_sat", bus.beat_cnt_o, {16'hFFFF, 48'h0});
`else
    chk("cnt_off", bus.beat_cnt_o, 0);
`endif

    // Randomized traffic vs reference model
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    lk = -1;
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      md[i] = '0;
      ml[i] = 0;
      mc[i] = 0;
    end
    for (int c = 0; c < 2000; c++) begin
      logic [N-1:0]  en, ordy, ev, el;
      logic          v, l;
      logic [DW-1:0] d;
      int            dest;
      logic [63:0]   ecnt;
      en   = N'($urandom);
      ordy = N'($urandom);
      v    = ($urandom_range(3) != 0);
      l    = ($urandom_range(2) == 0);
      d    = DW'($urandom);
      drive(en, ordy, v, d, l);
      dest = -1;
      if (lk >= 0) begin
        if (!mv[lk] || ordy[lk]) dest = lk;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (dest < 0 && en[i] && (!mv[i] || ordy[i])) dest = i;
        end
      end
      #1 chk("rnd_rdy", bus.in_rdy_o, dest >= 0);
      for (int i = 0; i < N; i++) begin
        if (mv[i] && ordy[i] && mc[i] < 65535) mc[i]++;
        if (v && dest == i) begin
          mv[i] = 1;
          md[i] = d;
          ml[i] = l;
        end else if (ordy[i]) begin
          mv[i] = 0;
        end
      end
      if (v && dest >= 0) begin
        if (lk < 0 && !l) lk = dest;
        else if (lk >= 0 && l) lk = -1;
      end
      tick;
      ev = '0;
      el = '0;
      ecnt = '0;
      for (int i = 0; i < N; i++) begin
        ev[i] = mv[i];
        el[i] = mv[i] & ml[i];
        ecnt[i*16 +: 16] = 16'(mc[i]);
        if (mv[i]) chk("rnd_dat", bus.out_data_o[i], md[i]);
      end
      chk("rnd_vld", bus.out_vld_o, ev);
      chk("rnd_last", bus.out_last_o & ev, el);
      chk("rnd_busy", bus.busy_o, lk >= 0);
      chk("rnd_idx", bus.lock_idx_o, (lk < 0) ? 0 : lk);
`ifdef PRIORITY_DISPATCH_CNT_EN
      chk("rnd_cnt", bus.beat_cnt_o, ecnt);
`else
      chk("rnd_cnt", bus.beat_cnt_o, 0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/priority_dispatch.md
Name: priority_dispatch

Overview:
- Single-source, multi-sink stream distributor; the fan-out counterpart to the fixed-priority input select used on the gather side.
- Each accepted upstream beat is routed to the lowest-index enabled output whose one-entry output register can take it.
- Multi-beat packets (framed by last) stay locked to one output until the last beat.
- Sits between an injection point and N parallel consumers, e.g. VC or port queues.

Parameters:
- OutputWidth, 4, number of downstream channels (>=1).
- DataWidth, 8, payload width in bits.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_vld_i  input  1  upstream beat valid
- in_rdy_o  output  1  upstream ready
- in_data_i  input  DataWidth  upstream payload
- in_last_i  input  1  final beat of packet
- en_mask_i  input  OutputWidth  outputs eligible for a new packet
- out_vld_o  output  OutputWidth  per-output valid
- out_rdy_i  input  OutputWidth  per-output ready
- out_data_o  output  OutputWidth x DataWidth  per-output payload (packed 2-D)
- out_last_o  output  OutputWidth  per-output last flag
- busy_o  output  1  1 while in LOCKED state
- lock_idx_o  output  $clog2(OutputWidth) (min 1)  locked output index, 0 when IDLE
- beat_cnt_o  output  OutputWidth x 16  per-output beat counters (see Optional Feature)

Behaviour:
- Reset (async assert, sync-to-clk deassert not required inside block):
  - all out_vld_o=0; out_data_o=0; out_last_o=0.
  - state=IDLE; lock_idx_o=0; busy_o=0; counters=0.
- Per-output slot free[i] = ~out_vld_o[i] | out_rdy_i[i]. Same-cycle drain+refill is allowed, giving full throughput.
- IDLE:
  - cand = en_mask_i & free; target = cand & ~(cand-1), one-hot, lowest index wins.
  - in_rdy_o = |cand.
- LOCKED:
  - target = one-hot(lock_idx); in_rdy_o = free[lock_idx].
  - en_mask_i is ignored; a mask change never splits a packet.
- Accept = in_vld_i & in_rdy_o. On accept:
  - target slot loads data/last; its out_vld_o is 1 next cycle. Latency is exactly 1 cycle.
- Transitions:
  - IDLE + accept with last=0 -> LOCKED, lock_idx=index(target).
  - IDLE + accept with last=1 -> stays IDLE (single-beat packet).
  - LOCKED + accept with last=1 -> IDLE, lock_idx=0.
  - LOCKED otherwise holds.
- Output slot i:
  - Clears vld on out_rdy_i[i] when it is not reloaded.
  - Holds data/last stable while vld & ~rdy.
  - Non-target slots are unaffected by an upstream accept.
- in_rdy_o is a function of state, en_mask_i and out_rdy_i/out_vld_o only. It never depends on in_vld_i; no combinational in_vld_i->in_rdy_o path.
- Boundary cases:
  - en_mask_i=0 in IDLE -> in_rdy_o=0.
  - All enabled slots full and not draining -> in_rdy_o=0.
  - OutputWidth=1: lock_idx_o is always 0.
- Reset mid-packet: the packet is truncated; in-flight output beats are dropped; the next beat is treated as a new packet head.

Optional Feature:
- Macro PRIORITY_DISPATCH_CNT_EN.
- Defined:
  - beat_cnt_o[i] increments on out_vld_o[i]&out_rdy_i[i].
  - Saturates at 16'hFFFF.
  - Reset clears it to 0.
- Undefined: beat_cnt_o tied to 0 and no counter flops are instantiated; the port list is unchanged.

Test Plan:
- Single-beat priority: OutputWidth=4, en_mask=4'b1110, all out_rdy=1, send data 8'hA5 last=1 -> next cycle out_vld=4'b0010, out_data[1]=8'hA5, out_last[1]=1; state stays IDLE.
- Back-pressure fallover: out_rdy=4'b0000, en_mask=4'b1111, send 4 single beats 8'h01..8'h04 -> land on outputs 0,1,2,3 respectively, then in_rdy_o=0. Raise out_rdy[2] -> in_rdy_o=1 and the next beat goes to output 2.
- Packet lock: beats 8'h10 (last=0), 8'h11 (last=0), 8'h12 (last=1) with en_mask=4'b0100. After the first beat, change en_mask to 4'b0001 -> all 3 beats appear on output 2 in order; busy_o=1 and lock_idx_o=2 until the last beat, then busy_o=0.
- Locked stall: while LOCKED on output 1, hold out_rdy[1]=0 with out_vld[1]=1 and outputs 0,2 free -> in_rdy_o=0. No beat leaks to another output; out_data[1] stays stable.
- Reset mid-packet: assert rst_n=0 asynchronously mid-clock after the first beat of a 3-beat packet -> out_vld_o=0 immediately, busy_o=0. After release, beat 8'h77 last=1 with en_mask=4'b0001 goes to output 0.
- Counters (PRIORITY_DISPATCH_CNT_EN defined): 300 beats drained on output 3 -> beat_cnt_o[3]=300, others 0. Force 70000 handshakes -> counter saturates at 16'hFFFF. With the macro undefined, all counters read 0.
